// File: rtl/hs_sync_sink_if.sv
// Bundle of signals between hs_sync_sink and its neighbours: the four-phase
// bundled-data upstream channel plus the valid/ready FIFO head and status.
interface hs_sync_sink_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             Rreq;
  logic [WIDTH-1:0] Rdata;
  logic             Rack;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic [15:0]      tok_cnt;

  modport slave (
    input  Rreq, Rdata, out_ready,
    output Rack, out_valid, out_data, count, tok_cnt
  );

  modport master (
    output Rreq, Rdata, out_ready,
    input  Rack, out_valid, out_data, count, tok_cnt
  );
endinterface

// File: rtl/hs_sync_sink.sv
// Four-phase bundled-data to synchronous FIFO sink.
// Rreq is brought into clk through a two-flop synchroniser; each complete
// four-phase cycle pushes one Rdata word into a DEPTH-entry FIFO that is
// drained through a valid/ready port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | Rack=0, waiting for sreq=1 and a free FIFO slot
// ACKD  | Rack=1, token pushed, waiting for sreq to return to 0
module hs_sync_sink #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  hs_sync_sink_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACKD = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             sync1_q;
  logic             sreq_q;
  logic             rack_q;
  logic             push;
  logic             pop;
  logic             full;
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [15:0]      tok_q;
  logic [WIDTH-1:0] mem [DEPTH];

  // Full is judged on the registered count, so a pop on this edge does not
  // make room for a push on the same edge.
  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && bus.out_ready;

  // Two-flop synchroniser for the asynchronous request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sreq_q  <= 1'b0;
    end else begin
      sync1_q <= bus.Rreq;
      sreq_q  <= sync1_q;
    end
  end

  // Next-state and push decode; push only ever happens on leaving IDLE.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sreq_q && !full) begin
          push    = 1'b1;
          state_d = ACKD;
        end
      end
      ACKD: begin
        if (!sreq_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, with Rack kept in its own flop so it is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rack_q  <= (state_d == ACKD);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Accepted-token counter, wraps silently at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tok_q <= '0;
    end else if (push) begin
      tok_q <= tok_q + 16'd1;
    end
  end

  // Storage is not reset; Rdata is captured only on the push edge.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.Rdata;
  end

  assign bus.Rack      = rack_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem[rptr_q];
  assign bus.count     = count_q;
  assign bus.tok_cnt   = tok_q;
endmodule
